// File: rtl/alu_rr_if.sv
// Client/ALU-side bundle of the round-robin ALU sequencer.
// The sequencer uses the slave view; the clients and the ALU use the master view.
interface alu_rr_if #(
    parameter int DATA_W = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [2*DATA_W+4:0]   req0_op;
    logic                  rsp0_valid;
    logic                  rsp0_ready;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [2*DATA_W+4:0]   req1_op;
    logic                  rsp1_valid;
    logic                  rsp1_ready;

    logic [DATA_W-1:0]     rsp_result;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [1:0]            alu_main_sel;
    logic [1:0]            alu_sub_sel;
    logic                  alu_cin;
    logic [DATA_W-1:0]     alu_result;

    modport slave (
        input  req0_valid, req0_op, rsp0_ready,
        input  req1_valid, req1_op, rsp1_ready,
        input  alu_result,
        output req0_ready, rsp0_valid,
        output req1_ready, rsp1_valid,
        output rsp_result,
        output alu_a, alu_b, alu_main_sel, alu_sub_sel, alu_cin
    );

    modport master (
        output req0_valid, req0_op, rsp0_ready,
        output req1_valid, req1_op, rsp1_ready,
        output alu_result,
        input  req0_ready, rsp0_valid,
        input  req1_ready, rsp1_valid,
        input  rsp_result,
        input  alu_a, alu_b, alu_main_sel, alu_sub_sel, alu_cin
    );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Shares one external ALU between two requesters: round-robin arbitration,
// operand latching, result capture after ALU_LAT cycles, valid/ready on both sides.
module alu_rr_sequencer #(
    parameter int DATA_W  = 4,
    parameter int ALU_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_rr_if.slave  bus,
    output logic     busy,
    output logic     grant_id
);
    localparam int OP_W  = 2*DATA_W + 5;
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               last_grant;
    logic [CNT_W-1:0]   lat_cnt;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [1:0]         main_q;
    logic [1:0]         sub_q;
    logic               cin_q;
    logic [DATA_W-1:0]  result_q;

    logic               both_valid;
    logic               any_valid;
    logic               winner;
    logic [OP_W-1:0]    win_op;
    logic               accept;
    logic               exec_done;
    logic               rsp_take;

    // Arbitration and transaction events; readies are masked during reset
    // so no handshake can complete on a cycle whose state update is discarded.
    always_comb begin
        both_valid = bus.req0_valid && bus.req1_valid;
        any_valid  = bus.req0_valid || bus.req1_valid;
        winner     = both_valid ? !last_grant : bus.req1_valid;
        win_op     = winner ? bus.req1_op : bus.req0_op;
        accept     = (state == IDLE) && any_valid && !rst;
        exec_done  = (state == EXEC) && (lat_cnt == LAT_LAST);
        rsp_take   = (state == RESP) && (grant_id ? bus.rsp1_ready : bus.rsp0_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:    if (exec_done) state_nxt = RESP;
            RESP:    if (rsp_take)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready   = accept && !winner;
        bus.req1_ready   = accept && winner;
        bus.rsp0_valid   = (state == RESP) && !grant_id;
        bus.rsp1_valid   = (state == RESP) && grant_id;
        bus.rsp_result   = result_q;
        busy             = (state != IDLE);
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        bus.alu_main_sel = '0;
        bus.alu_sub_sel  = '0;
        bus.alu_cin      = 1'b0;
        if (state != IDLE) begin
            bus.alu_a        = a_q;
            bus.alu_b        = b_q;
            bus.alu_main_sel = main_q;
            bus.alu_sub_sel  = sub_q;
            bus.alu_cin      = cin_q;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            lat_cnt    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            main_q     <= '0;
            sub_q      <= '0;
            cin_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                a_q      <= win_op[OP_W-1 -: DATA_W];
                b_q      <= win_op[DATA_W+4 -: DATA_W];
                main_q   <= win_op[4:3];
                sub_q    <= win_op[2:1];
                cin_q    <= win_op[0];
                grant_id <= winner;
                lat_cnt  <= '0;
            end
            if (state == EXEC) begin
                lat_cnt <= lat_cnt + 1'b1;
                if (exec_done) begin
                    result_q <= bus.alu_result;
                end
            end
            if (rsp_take) begin
                last_grant <= grant_id;
            end
        end
    end
endmodule
